// File: rtl/bram_port_arbiter.sv
// -----------------------------------------------------------------------------
// bram_port_arbiter
//
// Connects two independent requesters to the two ports of a true dual-port
// block RAM. Requester 0 always drives RAM port A and requester 1 always
// drives RAM port B. Both requests issue in the same cycle unless they
// collide. A collision is both valid, with the same address and at least one
// of them writing. On a collision only the requester named by a one-bit
// priority register is accepted. Priority then flips to the stalled side, so
// neither side waits more than one consecutive collision cycle.
//
// Reads have a fixed two-cycle latency. The RAM returns data the cycle after
// the read edge. That data is captured into a per-requester hold register and
// presented with rvalid one cycle later. The hold register keeps the last
// delivered word while rvalid is low.
//
// Ports
//   clk, rst            sole clock; asynchronous active-high reset
//   rN_valid/ready      requester N handshake (ready is combinational)
//   rN_addr/we/be/wdata requester N command
//   rN_rvalid/rdata     requester N read return (one-cycle pulse, held data)
//   {a,b}_addr/re/we/be/wd  RAM port command (A <- r0, B <- r1)
//   {a,b}_rd            RAM synchronous read data
//   coll_count          saturating count of collision cycles
// -----------------------------------------------------------------------------
module bram_port_arbiter #(
  parameter int unsigned ADDRWIDTH = 10,
  parameter int unsigned DATAWIDTH = 36,
  parameter int unsigned BYTEWIDTH = 9,
  localparam int unsigned NB = DATAWIDTH / BYTEWIDTH
) (
  input  logic                 clk,
  input  logic                 rst,

  // Requester 0
  input  logic                 r0_valid,
  output logic                 r0_ready,
  input  logic [ADDRWIDTH-1:0] r0_addr,
  input  logic                 r0_we,
  input  logic [NB-1:0]        r0_be,
  input  logic [DATAWIDTH-1:0] r0_wdata,
  output logic                 r0_rvalid,
  output logic [DATAWIDTH-1:0] r0_rdata,

  // Requester 1
  input  logic                 r1_valid,
  output logic                 r1_ready,
  input  logic [ADDRWIDTH-1:0] r1_addr,
  input  logic                 r1_we,
  input  logic [NB-1:0]        r1_be,
  input  logic [DATAWIDTH-1:0] r1_wdata,
  output logic                 r1_rvalid,
  output logic [DATAWIDTH-1:0] r1_rdata,

  // RAM port A (owned by requester 0)
  output logic [ADDRWIDTH-1:0] a_addr,
  output logic                 a_re,
  output logic                 a_we,
  output logic [NB-1:0]        a_be,
  output logic [DATAWIDTH-1:0] a_wd,
  input  logic [DATAWIDTH-1:0] a_rd,

  // RAM port B (owned by requester 1)
  output logic [ADDRWIDTH-1:0] b_addr,
  output logic                 b_re,
  output logic                 b_we,
  output logic [NB-1:0]        b_be,
  output logic [DATAWIDTH-1:0] b_wd,
  input  logic [DATAWIDTH-1:0] b_rd,

  // Status
  output logic [15:0]          coll_count
);

  logic                 collision;

  // 0: requester 0 wins the next collision, 1: requester 1 wins.
  logic                 prio_q, prio_d;
  logic [15:0]          coll_count_q, coll_count_d;

  // Bit 0: read issued last cycle (RAM data now on p_rd).
  // Bit 1: read issued two cycles ago (data now in the hold register).
  logic [1:0]           r0_pipe_q, r0_pipe_d;
  logic [1:0]           r1_pipe_q, r1_pipe_d;
  logic [DATAWIDTH-1:0] r0_hold_q, r0_hold_d;
  logic [DATAWIDTH-1:0] r1_hold_q, r1_hold_d;

  // Two reads of the same word are harmless on a dual-port RAM, so only a
  // write on either side makes a same-address pair a collision. A write with
  // all byte enables low still counts as a write here.
  always_comb begin : collision_detect
    collision = r0_valid & r1_valid & (r0_addr == r1_addr) & (r0_we | r1_we);
  end

  // Ready depends only on valids, addresses, write flags and prio, never on
  // byte enables or data, so requesters can build on it without timing loops.
  always_comb begin : grant
    r0_ready = 1'b0;
    r1_ready = 1'b0;
    if (!rst) begin
      r0_ready = !collision || (prio_q == 1'b0);
      r1_ready = !collision || (prio_q == 1'b1);
    end
  end

  // Issue is purely combinational. Address, byte enables and data pass
  // straight through; only the strobes are qualified by the handshake.
  always_comb begin : issue
    a_addr = r0_addr;
    a_be   = r0_be;
    a_wd   = r0_wdata;
    a_we   = r0_valid & r0_ready & r0_we;
    a_re   = r0_valid & r0_ready & ~r0_we;

    b_addr = r1_addr;
    b_be   = r1_be;
    b_wd   = r1_wdata;
    b_we   = r1_valid & r1_ready & r1_we;
    b_re   = r1_valid & r1_ready & ~r1_we;
  end

  always_comb begin : next_state
    // Hand priority to whoever was just stalled.
    prio_d = prio_q;
    if (collision) begin
      prio_d = ~prio_q;
    end

    coll_count_d = coll_count_q;
    if (collision && (coll_count_q != 16'hFFFF)) begin
      coll_count_d = coll_count_q + 16'd1;
    end

    r0_pipe_d = {r0_pipe_q[0], a_re};
    r1_pipe_d = {r1_pipe_q[0], b_re};

    // Capture RAM data in the cycle it is valid. Back-to-back reads overwrite
    // the hold register each cycle, which lines up with back-to-back rvalid.
    r0_hold_d = r0_hold_q;
    if (r0_pipe_q[0]) begin
      r0_hold_d = a_rd;
    end

    r1_hold_d = r1_hold_q;
    if (r1_pipe_q[0]) begin
      r1_hold_d = b_rd;
    end
  end

  always_ff @(posedge clk or posedge rst) begin : state_regs
    if (rst) begin
      prio_q       <= 1'b0;
      coll_count_q <= 16'h0000;
      r0_pipe_q    <= 2'b00;
      r1_pipe_q    <= 2'b00;
      r0_hold_q    <= '0;
      r1_hold_q    <= '0;
    end else begin
      prio_q       <= prio_d;
      coll_count_q <= coll_count_d;
      r0_pipe_q    <= r0_pipe_d;
      r1_pipe_q    <= r1_pipe_d;
      r0_hold_q    <= r0_hold_d;
      r1_hold_q    <= r1_hold_d;
    end
  end

  always_comb begin : outputs
    r0_rvalid  = r0_pipe_q[1];
    r1_rvalid  = r1_pipe_q[1];
    r0_rdata   = r0_hold_q;
    r1_rdata   = r1_hold_q;
    coll_count = coll_count_q;
  end

endmodule

// File: tb/tb_bram_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_bram_port_arbiter
//
// Self-checking bench for bram_port_arbiter. A behavioural dual-port RAM is
// attached to ports A and B. Directed scenarios cover reset, parallel writes,
// write/write collision, read-after-write, the read/read exception, reset
// during a read and counter saturation. A randomized phase compares the DUT
// against a transaction-level model. That model keeps its own memory image,
// the priority owner and the collision count. It also keeps per-requester
// queues of (due cycle, data) for reads.
// -----------------------------------------------------------------------------
module tb_bram_port_arbiter;

  localparam int unsigned AW = 10;
  localparam int unsigned DW = 36;
  localparam int unsigned BW = 9;
  localparam int unsigned NB = DW / BW;

  typedef struct {
    int          due;
    logic [DW-1:0] data;
  } rd_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;

  logic          r0_valid = 1'b0;
  logic          r0_ready;
  logic [AW-1:0] r0_addr = '0;
  logic          r0_we = 1'b0;
  logic [NB-1:0] r0_be = '0;
  logic [DW-1:0] r0_wdata = '0;
  logic          r0_rvalid;
  logic [DW-1:0] r0_rdata;

  logic          r1_valid = 1'b0;
  logic          r1_ready;
  logic [AW-1:0] r1_addr = '0;
  logic          r1_we = 1'b0;
  logic [NB-1:0] r1_be = '0;
  logic [DW-1:0] r1_wdata = '0;
  logic          r1_rvalid;
  logic [DW-1:0] r1_rdata;

  logic [AW-1:0] a_addr, b_addr;
  logic          a_re, a_we, b_re, b_we;
  logic [NB-1:0] a_be, b_be;
  logic [DW-1:0] a_wd, b_wd;
  logic [DW-1:0] a_rd = '0;
  logic [DW-1:0] b_rd = '0;
  logic [15:0]   coll_count;

  int n_checks = 0;
  int n_fails  = 0;
  int cyc      = 0;

  always #5 clk = ~clk;

  bram_port_arbiter #(
    .ADDRWIDTH(AW),
    .DATAWIDTH(DW),
    .BYTEWIDTH(BW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .r0_valid  (r0_valid),
    .r0_ready  (r0_ready),
    .r0_addr   (r0_addr),
    .r0_we     (r0_we),
    .r0_be     (r0_be),
    .r0_wdata  (r0_wdata),
    .r0_rvalid (r0_rvalid),
    .r0_rdata  (r0_rdata),
    .r1_valid  (r1_valid),
    .r1_ready  (r1_ready),
    .r1_addr   (r1_addr),
    .r1_we     (r1_we),
    .r1_be     (r1_be),
    .r1_wdata  (r1_wdata),
    .r1_rvalid (r1_rvalid),
    .r1_rdata  (r1_rdata),
    .a_addr    (a_addr),
    .a_re      (a_re),
    .a_we      (a_we),
    .a_be      (a_be),
    .a_wd      (a_wd),
    .a_rd      (a_rd),
    .b_addr    (b_addr),
    .b_re      (b_re),
    .b_we      (b_we),
    .b_be      (b_be),
    .b_wd      (b_wd),
    .b_rd      (b_rd),
    .coll_count(coll_count)
  );

  // Dual-port RAM: byte-enabled writes, registered read (read-first).
  logic [DW-1:0] ram [1024];
  always @(posedge clk) begin
    for (int k = 0; k < NB; k++) begin
      if (a_we && a_be[k]) ram[a_addr][k*BW +: BW] <= a_wd[k*BW +: BW];
      if (b_we && b_be[k]) ram[b_addr][k*BW +: BW] <= b_wd[k*BW +: BW];
    end
    if (a_re) a_rd <= ram[a_addr];
    if (b_re) b_rd <= ram[b_addr];
  end

  // Cycles start 1 time unit after posedge (inputs change here).
  task automatic next_cycle();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Samples mid-cycle and checks the port invariant every time.
  task automatic sample();
    @(negedge clk);
    n_checks++;
    if ((a_we && a_re) || (b_we && b_re) || (a_we && b_we && a_addr == b_addr)) begin
      n_fails++;
      $display("FAIL port_invariant cycle %0d: a_we=%b a_re=%b b_we=%b b_re=%b a_addr=%0d b_addr=%0d, required no conflicting strobes",
               cyc, a_we, a_re, b_we, b_re, a_addr, b_addr);
    end
  endtask

  task automatic drive0(input logic v, input logic [AW-1:0] ad, input logic we,
                        input logic [NB-1:0] be, input logic [DW-1:0] wd);
    r0_valid = v; r0_addr = ad; r0_we = we; r0_be = be; r0_wdata = wd;
  endtask

  task automatic drive1(input logic v, input logic [AW-1:0] ad, input logic we,
                        input logic [NB-1:0] be, input logic [DW-1:0] wd);
    r1_valid = v; r1_addr = ad; r1_we = we; r1_be = be; r1_wdata = wd;
  endtask

  task automatic idle_inputs();
    drive0(1'b0, '0, 1'b0, '0, '0);
    drive1(1'b0, '0, 1'b0, '0, '0);
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    repeat (2) next_cycle();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive0(1'b1, AW'(1), 1'b1, '1, DW'(36'h0AAAAAAAA));
    drive1(1'b1, AW'(2), 1'b0, '0, '0);
    repeat (2) next_cycle();
    sample();
    n_checks++;
    if ({r0_ready, r1_ready, a_we, a_re, b_we, b_re} !== 6'b0) begin
      n_fails++;
      $display("FAIL reset_strobes: got rdy/we/re=%b required 000000",
               {r0_ready, r1_ready, a_we, a_re, b_we, b_re});
    end
    n_checks++;
    if ({r0_rvalid, r1_rvalid} !== 2'b00 || r0_rdata !== '0 || r1_rdata !== '0 ||
        coll_count !== 16'h0) begin
      n_fails++;
      $display("FAIL reset_state: got rvalid=%b rdata0=%h rdata1=%h cc=%h required all zero",
               {r0_rvalid, r1_rvalid}, r0_rdata, r1_rdata, coll_count);
    end
    rst = 1'b0;
    sample();
    n_checks++;
    if ({r0_ready, r1_ready, a_we, b_re} !== 4'b1111) begin
      n_fails++;
      $display("FAIL reset_release: got rdy0/rdy1/a_we/b_re=%b required 1111",
               {r0_ready, r1_ready, a_we, b_re});
    end
    next_cycle();
    idle_inputs();
  endtask

  task automatic test_parallel_write();
    do_reset();
    drive0(1'b1, AW'(5), 1'b1, '1, DW'(36'h111111111));
    drive1(1'b1, AW'(9), 1'b1, '1, DW'(36'h222222222));
    sample();
    n_checks++;
    if ({r0_ready, r1_ready, a_we, b_we} !== 4'b1111 || a_addr !== AW'(5) || b_addr !== AW'(9)) begin
      n_fails++;
      $display("FAIL parallel_write: got rdy/we=%b a_addr=%0d b_addr=%0d required 1111,5,9",
               {r0_ready, r1_ready, a_we, b_we}, a_addr, b_addr);
    end
    next_cycle();
    idle_inputs();
    sample();
    n_checks++;
    if (coll_count !== 16'h0) begin
      n_fails++;
      $display("FAIL parallel_write_count: got %0d required 0", coll_count);
    end
  endtask

  task automatic test_write_collision();
    do_reset();
    drive0(1'b1, AW'(3), 1'b1, '1, DW'(36'h0000000A0));
    drive1(1'b1, AW'(3), 1'b1, '1, DW'(36'h0000000B1));
    sample();
    n_checks++;
    if ({r0_ready, r1_ready, a_we, b_we} !== 4'b1010) begin
      n_fails++;
      $display("FAIL ww_collision_c1: got rdy0/rdy1/a_we/b_we=%b required 1010",
               {r0_ready, r1_ready, a_we, b_we});
    end
    next_cycle();
    drive0(1'b0, '0, 1'b0, '0, '0);
    sample();
    n_checks++;
    if ({r1_ready, b_we, a_we} !== 3'b110 || coll_count !== 16'd1) begin
      n_fails++;
      $display("FAIL ww_collision_c2: got rdy1/b_we/a_we=%b cc=%0d required 110, 1",
               {r1_ready, b_we, a_we}, coll_count);
    end
    // Priority should now sit with requester 1.
    next_cycle();
    drive0(1'b1, AW'(3), 1'b1, '1, DW'(36'h0000000C2));
    sample();
    n_checks++;
    if ({r0_ready, r1_ready} !== 2'b01) begin
      n_fails++;
      $display("FAIL ww_collision_prio: got rdy0/rdy1=%b required 01", {r0_ready, r1_ready});
    end
    next_cycle();
    idle_inputs();
    sample();
    n_checks++;
    if (coll_count !== 16'd2) begin
      n_fails++;
      $display("FAIL ww_collision_count: got %0d required 2", coll_count);
    end
  endtask

  task automatic test_read_after_write();
    do_reset();
    drive0(1'b1, AW'(7), 1'b1, '1, DW'(36'h123456789));
    sample();
    next_cycle();
    drive0(1'b0, '0, 1'b0, '0, '0);
    drive1(1'b1, AW'(7), 1'b0, '0, '0);
    sample();
    n_checks++;
    if ({r1_ready, b_re, b_we, r1_rvalid} !== 4'b1100) begin
      n_fails++;
      $display("FAIL raw_issue: got rdy1/b_re/b_we/rvalid1=%b required 1100",
               {r1_ready, b_re, b_we, r1_rvalid});
    end
    next_cycle();
    idle_inputs();
    sample();
    n_checks++;
    if (r1_rvalid !== 1'b0) begin
      n_fails++;
      $display("FAIL raw_t1: got rvalid1=%b required 0", r1_rvalid);
    end
    next_cycle();
    sample();
    n_checks++;
    if (r1_rvalid !== 1'b1 || r1_rdata !== DW'(36'h123456789)) begin
      n_fails++;
      $display("FAIL raw_t2: got rvalid1=%b rdata1=%h required 1, 123456789", r1_rvalid, r1_rdata);
    end
    next_cycle();
    sample();
    n_checks++;
    if (r1_rvalid !== 1'b0 || r1_rdata !== DW'(36'h123456789)) begin
      n_fails++;
      $display("FAIL raw_hold: got rvalid1=%b rdata1=%h required 0, 123456789", r1_rvalid, r1_rdata);
    end
  endtask

  // Runs right after read-after-write, so address 7 holds 36'h123456789.
  task automatic test_read_read();
    next_cycle();
    drive0(1'b1, AW'(7), 1'b0, '0, '0);
    drive1(1'b1, AW'(7), 1'b0, '0, '0);
    sample();
    n_checks++;
    if ({r0_ready, r1_ready, a_re, b_re} !== 4'b1111) begin
      n_fails++;
      $display("FAIL rr_issue: got rdy/re=%b required 1111", {r0_ready, r1_ready, a_re, b_re});
    end
    next_cycle();
    idle_inputs();
    sample();
    n_checks++;
    if ({r0_rvalid, r1_rvalid} !== 2'b00) begin
      n_fails++;
      $display("FAIL rr_t1: got rvalid=%b required 00", {r0_rvalid, r1_rvalid});
    end
    next_cycle();
    sample();
    n_checks++;
    if ({r0_rvalid, r1_rvalid} !== 2'b11 || r0_rdata !== DW'(36'h123456789) ||
        r1_rdata !== DW'(36'h123456789) || coll_count !== 16'd0) begin
      n_fails++;
      $display("FAIL rr_t2: got rvalid=%b rdata0=%h rdata1=%h cc=%0d required 11, 123456789 x2, 0",
               {r0_rvalid, r1_rvalid}, r0_rdata, r1_rdata, coll_count);
    end
  endtask

  task automatic test_reset_mid_read();
    do_reset();
    drive0(1'b1, AW'(12), 1'b1, '1, DW'(36'hABCDE1234));
    sample();
    next_cycle();
    drive0(1'b1, AW'(12), 1'b0, '0, '0);
    sample();
    next_cycle();
    idle_inputs();
    sample();
    next_cycle();
    sample();
    n_checks++;
    if (r0_rvalid !== 1'b1 || r0_rdata !== DW'(36'hABCDE1234)) begin
      n_fails++;
      $display("FAIL rst_mid_prime: got rvalid0=%b rdata0=%h required 1, abcde1234", r0_rvalid, r0_rdata);
    end
    next_cycle();
    drive0(1'b1, AW'(12), 1'b0, '0, '0);
    sample();
    next_cycle();
    // Requests still presented while reset hits.
    drive1(1'b1, AW'(20), 1'b1, '1, DW'(36'h5));
    rst = 1'b1;
    #1;
    n_checks++;
    if ({r0_ready, r1_ready, a_we, a_re, b_we, b_re, r0_rvalid, r1_rvalid} !== 8'b0 ||
        r0_rdata !== '0 || r1_rdata !== '0 || coll_count !== 16'h0) begin
      n_fails++;
      $display("FAIL rst_mid_immediate: got ctl=%b rdata0=%h rdata1=%h cc=%h required all zero",
               {r0_ready, r1_ready, a_we, a_re, b_we, b_re, r0_rvalid, r1_rvalid},
               r0_rdata, r1_rdata, coll_count);
    end
    idle_inputs();
    repeat (2) next_cycle();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      sample();
      n_checks++;
      if (r0_rvalid !== 1'b0) begin
        n_fails++;
        $display("FAIL rst_mid_discard cycle %0d after release: got rvalid0=%b required 0", i, r0_rvalid);
      end
      next_cycle();
    end
  endtask

  task automatic test_random();
    rd_t           q0[$];
    rd_t           q1[$];
    rd_t           e;
    logic [DW-1:0] ref_mem [8];
    logic          pv [2];
    logic [AW-1:0] pa [2];
    logic          pw [2];
    logic [NB-1:0] pb [2];
    logic [DW-1:0] pd [2];
    logic [DW-1:0] last [2];
    logic          rdy [2];
    logic          g [2];
    logic          ev;
    logic          mprio;
    logic          coll;
    int            mcount;

    do_reset();
    for (int i = 0; i < 8; i++) begin
      ref_mem[i] = DW'({$urandom, $urandom});
      drive0(1'b1, AW'(i), 1'b1, '1, ref_mem[i]);
      sample();
      next_cycle();
    end
    idle_inputs();
    for (int n = 0; n < 2; n++) begin
      pv[n] = 1'b0; pa[n] = '0; pw[n] = 1'b0; pb[n] = '0; pd[n] = '0; last[n] = '0;
    end
    mprio  = 1'b0;
    mcount = 0;

    for (int i = 0; i < 3004; i++) begin
      for (int n = 0; n < 2; n++) begin
        if (!pv[n] && i < 3000 && $urandom_range(0, 3) != 0) begin
          pv[n] = 1'b1;
          pa[n] = AW'($urandom_range(0, 7));
          pw[n] = 1'($urandom_range(0, 1));
          pb[n] = NB'($urandom);
          pd[n] = DW'({$urandom, $urandom});
        end
      end
      drive0(pv[0], pa[0], pw[0], pb[0], pd[0]);
      drive1(pv[1], pa[1], pw[1], pb[1], pd[1]);
      sample();

      coll   = pv[0] && pv[1] && (pa[0] == pa[1]) && (pw[0] || pw[1]);
      rdy[0] = !coll || (mprio == 1'b0);
      rdy[1] = !coll || (mprio == 1'b1);
      g[0]   = pv[0] && rdy[0];
      g[1]   = pv[1] && rdy[1];

      n_checks++;
      if ({r0_ready, r1_ready} !== {rdy[0], rdy[1]}) begin
        n_fails++;
        $display("FAIL rand_ready cycle %0d: got %b required %b", cyc, {r0_ready, r1_ready}, {rdy[0], rdy[1]});
      end
      n_checks++;
      if ({a_we, a_re, b_we, b_re} !== {g[0] && pw[0], g[0] && !pw[0], g[1] && pw[1], g[1] && !pw[1]}) begin
        n_fails++;
        $display("FAIL rand_strobes cycle %0d: got a_we/a_re/b_we/b_re=%b required %b", cyc,
                 {a_we, a_re, b_we, b_re}, {g[0] && pw[0], g[0] && !pw[0], g[1] && pw[1], g[1] && !pw[1]});
      end
      n_checks++;
      if (coll_count !== 16'(mcount)) begin
        n_fails++;
        $display("FAIL rand_count cycle %0d: got %0d required %0d", cyc, coll_count, mcount);
      end

      ev = 1'b0;
      if (q0.size() > 0) if (q0[0].due == cyc) ev = 1'b1;
      if (ev) begin
        e = q0.pop_front();
        last[0] = e.data;
      end
      n_checks++;
      if (r0_rvalid !== ev || r0_rdata !== last[0]) begin
        n_fails++;
        $display("FAIL rand_read0 cycle %0d: got rvalid=%b rdata=%h required %b, %h", cyc,
                 r0_rvalid, r0_rdata, ev, last[0]);
      end
      ev = 1'b0;
      if (q1.size() > 0) if (q1[0].due == cyc) ev = 1'b1;
      if (ev) begin
        e = q1.pop_front();
        last[1] = e.data;
      end
      n_checks++;
      if (r1_rvalid !== ev || r1_rdata !== last[1]) begin
        n_fails++;
        $display("FAIL rand_read1 cycle %0d: got rvalid=%b rdata=%h required %b, %h", cyc,
                 r1_rvalid, r1_rdata, ev, last[1]);
      end

      // Reads see memory before this cycle's writes.
      if (g[0] && !pw[0]) q0.push_back('{due: cyc + 2, data: ref_mem[pa[0][2:0]]});
      if (g[1] && !pw[1]) q1.push_back('{due: cyc + 2, data: ref_mem[pa[1][2:0]]});
      for (int n = 0; n < 2; n++) begin
        if (g[n] && pw[n]) begin
          for (int k = 0; k < NB; k++) begin
            if (pb[n][k]) ref_mem[pa[n][2:0]][k*BW +: BW] = pd[n][k*BW +: BW];
          end
        end
        if (g[n]) pv[n] = 1'b0;
      end
      if (coll) begin
        mprio = rdy[0] ? 1'b1 : 1'b0;  // the stalled side owns the next tie
        if (mcount < 65535) mcount++;
      end
      next_cycle();
    end
    idle_inputs();
  endtask

  task automatic test_saturation();
    logic p;
    do_reset();
    drive0(1'b1, AW'(3), 1'b1, '1, DW'(36'h1));
    drive1(1'b1, AW'(3), 1'b1, '0, DW'(36'h2));
    p = 1'b0;
    for (int i = 0; i < 65537; i++) begin
      sample();
      if (i < 16) begin
        n_checks++;
        if ({r0_ready, r1_ready} !== (p ? 2'b01 : 2'b10)) begin
          n_fails++;
          $display("FAIL sat_alternate step %0d: got rdy0/rdy1=%b required %b", i,
                   {r0_ready, r1_ready}, (p ? 2'b01 : 2'b10));
        end
      end
      if (i == 65534 || i == 65535) begin
        n_checks++;
        if (coll_count !== 16'(i)) begin
          n_fails++;
          $display("FAIL sat_ramp step %0d: got %h required %h", i, coll_count, 16'(i));
        end
      end
      p = ~p;
      next_cycle();
    end
    sample();
    n_checks++;
    if (coll_count !== 16'hFFFF) begin
      n_fails++;
      $display("FAIL sat_final: got %h required ffff", coll_count);
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_parallel_write();
    test_write_collision();
    test_read_after_write();
    test_read_read();
    test_reset_mid_read();
    test_random();
    test_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
